// File: rtl/pi_client_port_pkg.sv
// Shared defaults and helpers for the pi-switch client endpoint.
package pi_client_port_pkg;

    localparam int N_DEF   = 8;
    localparam int D_W_DEF = 32;
    localparam int A_W_DEF = $clog2(N_DEF) + 1;

    // Source of the next registered packet on the switch-facing port
    typedef enum logic [1:0] {
        SEL_IDLE   = 2'd0,
        SEL_BOUNCE = 2'd1,
        SEL_INJECT = 2'd2
    } out_sel_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            sat_inc16 = val;
        end else begin
            sat_inc16 = val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/pi_client_port_if.sv
// Switch-port and client-port signal bundle of one pi-switch leaf endpoint.
interface pi_client_port_if
    import pi_client_port_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int D_W = D_W_DEF
);
    logic           noc_i_v;
    logic           noc_i_defl;
    logic [A_W-1:0] noc_i_addr;
    logic [D_W-1:0] noc_i_data;
    logic           noc_o_v;
    logic [A_W-1:0] noc_o_addr;
    logic [D_W-1:0] noc_o_data;
    logic           tx_v;
    logic           tx_rdy;
    logic [A_W-1:0] tx_addr;
    logic [D_W-1:0] tx_data;
    logic           rx_v;
    logic           rx_rdy;
    logic [D_W-1:0] rx_data;
    logic [15:0]    bounce_cnt;

    modport slave (
        input  noc_i_v, noc_i_defl, noc_i_addr, noc_i_data,
        input  tx_v, tx_addr, tx_data, rx_rdy,
        output noc_o_v, noc_o_addr, noc_o_data,
        output tx_rdy, rx_v, rx_data, bounce_cnt
    );

    modport master (
        output noc_i_v, noc_i_defl, noc_i_addr, noc_i_data,
        output tx_v, tx_addr, tx_data, rx_rdy,
        input  noc_o_v, noc_o_addr, noc_o_data,
        input  tx_rdy, rx_v, rx_data, bounce_cnt
    );
endinterface

// File: rtl/pi_client_port_fifo.sv
// Synchronous FIFO with clock enable; pointers carry one extra wrap bit so
// full and empty are told apart by the MSB.
module pi_client_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push_s, do_pop_s;

    assign full_o    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign do_push_s = ce && push_i && !full_o;
    assign do_pop_s  = ce && pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q[PW-2:0]];

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[PW-2:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/pi_client_port.sv
// Leaf endpoint of the pi-switch BFT: ejects packets for this client, re-injects
// everything else the switch hands back, and injects client traffic in idle slots.
module pi_client_port
    import pi_client_port_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int A_W      = $clog2(N) + 1,
    parameter int D_W      = D_W_DEF,
    parameter int POSX     = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    pi_client_port_if.slave   bus
);
    localparam logic [A_W-1:0] POS_ADDR = A_W'(POSX);

    logic               tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [A_W+D_W-1:0] tx_head_s;
    logic               eject_s, bounce_s, inject_s;
    logic               defl_unused_s;
    out_sel_e           sel_s;

    logic               noc_o_v_q, noc_o_v_d;
    logic [A_W-1:0]     noc_o_addr_q, noc_o_addr_d;
    logic [D_W-1:0]     noc_o_data_q, noc_o_data_d;
    logic [15:0]        bounce_cnt_q, bounce_cnt_d;

    // The deflect flag does not change routing here: a packet for us is ejected either way.
    assign defl_unused_s = bus.noc_i_defl;

    // RX space is judged on the current flag, so a same-cycle pop never makes room.
    assign eject_s  = bus.noc_i_v && (bus.noc_i_addr == POS_ADDR) && !rx_full_s;
    assign bounce_s = bus.noc_i_v && !eject_s;
    assign inject_s = !bounce_s && !tx_empty_s;

    pi_client_fifo #(.W(A_W + D_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .push_i  (bus.tx_v && !tx_full_s),
        .wdata_i ({bus.tx_addr, bus.tx_data}),
        .pop_i   (inject_s),
        .rdata_o (tx_head_s),
        .full_o  (tx_full_s),
        .empty_o (tx_empty_s)
    );

    pi_client_fifo #(.W(D_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .push_i  (eject_s),
        .wdata_i (bus.noc_i_data),
        .pop_i   (bus.rx_rdy && !rx_empty_s),
        .rdata_o (bus.rx_data),
        .full_o  (rx_full_s),
        .empty_o (rx_empty_s)
    );

    // Output-packet source select and bounce counter next-state
    always_comb begin
        sel_s        = SEL_IDLE;
        noc_o_v_d    = 1'b0;
        noc_o_addr_d = noc_o_addr_q;
        noc_o_data_d = noc_o_data_q;
        bounce_cnt_d = bounce_cnt_q;
        if (bounce_s) begin
            sel_s = SEL_BOUNCE;
        end else if (inject_s) begin
            sel_s = SEL_INJECT;
        end else begin
            sel_s = SEL_IDLE;
        end
        case (sel_s)
            SEL_BOUNCE: begin
                noc_o_v_d    = 1'b1;
                noc_o_addr_d = bus.noc_i_addr;
                noc_o_data_d = bus.noc_i_data;
                bounce_cnt_d = sat_inc16(bounce_cnt_q);
            end
            SEL_INJECT: begin
                noc_o_v_d    = 1'b1;
                noc_o_addr_d = tx_head_s[A_W+D_W-1:D_W];
                noc_o_data_d = tx_head_s[D_W-1:0];
            end
            default: begin
                noc_o_v_d = 1'b0;
            end
        endcase
    end

    // Output packet register and bounce counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            noc_o_v_q    <= 1'b0;
            noc_o_addr_q <= '0;
            noc_o_data_q <= '0;
            bounce_cnt_q <= 16'd0;
        end else if (ce) begin
            noc_o_v_q    <= noc_o_v_d;
            noc_o_addr_q <= noc_o_addr_d;
            noc_o_data_q <= noc_o_data_d;
            bounce_cnt_q <= bounce_cnt_d;
        end
    end

    assign bus.noc_o_v    = noc_o_v_q;
    assign bus.noc_o_addr = noc_o_addr_q;
    assign bus.noc_o_data = noc_o_data_q;
    assign bus.tx_rdy     = !tx_full_s;
    assign bus.rx_v       = !rx_empty_s;
    assign bus.bounce_cnt = bounce_cnt_q;

endmodule
